// File: rtl/ram_1w_1rs_stream.sv
// ram_1w_1rs_stream: symbol-masked simple-dual-port RAM
// with a valid/ready read pipeline of 1 or 2 stages.
module ram_1w_1rs_stream #(
   parameter int    wordCount      = 256,
   parameter int    wordWidth      = 32,
   parameter int    maskWidth      = 4,
   parameter int    readLatency    = 1,
   parameter string readUnderWrite = "writeFirst",
   parameter int    addressWidth   = (wordCount > 1) ?
                                     $clog2(wordCount) : 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    wr_en,
   input  logic [maskWidth-1:0]    wr_mask,
   input  logic [addressWidth-1:0] wr_addr,
   input  logic [wordWidth-1:0]    wr_data,
   input  logic                    rd_cmd_valid,
   output logic                    rd_cmd_ready,
   input  logic [addressWidth-1:0] rd_cmd_addr,
   output logic                    rd_rsp_valid,
   input  logic                    rd_rsp_ready,
   output logic [wordWidth-1:0]    rd_rsp_data
);

   localparam int          SW   = wordWidth / maskWidth;
   localparam int          LAST = readLatency - 1;
   localparam logic [31:0] WC   = wordCount;
   localparam bit          WF   = (readUnderWrite == "writeFirst");

   logic [wordWidth-1:0] r_mem [wordCount];

   logic                 r_vld [readLatency];
   logic [wordWidth-1:0] r_dat [readLatency];

   logic                 w_wr_inr;
   logic                 w_rd_inr;
   logic                 w_hit;
   logic                 w_stall;
   logic                 w_fire;
   logic [wordWidth-1:0] w_rd_word;

   assign w_wr_inr = (32'(wr_addr) < WC);
   assign w_rd_inr = (32'(rd_cmd_addr) < WC);
   assign w_hit    = wr_en && w_wr_inr &&
                     (wr_addr == rd_cmd_addr);

   assign w_stall      = r_vld[LAST] && !rd_rsp_ready;
   assign rd_cmd_ready = !w_stall;
   assign w_fire       = rd_cmd_valid && !w_stall;

   assign rd_rsp_valid = r_vld[LAST];
   assign rd_rsp_data  = r_dat[LAST];

   // masked store; out-of-range and in-reset writes are dropped
   always_ff @(posedge clk) begin
      if (resetn && wr_en && w_wr_inr) begin
         for (int i = 0; i < maskWidth; i++) begin
            if (wr_mask[i])
               r_mem[wr_addr][i*SW +: SW] <= wr_data[i*SW +: SW];
         end
      end
   end

   // read word, with same-cycle lane forwarding in writeFirst mode
   always_comb begin
      w_rd_word = '0;
      if (w_rd_inr) begin
         w_rd_word = r_mem[rd_cmd_addr];
         if (WF && w_hit) begin
            for (int i = 0; i < maskWidth; i++) begin
               if (wr_mask[i])
                  w_rd_word[i*SW +: SW] = wr_data[i*SW +: SW];
            end
         end
      end
   end

   // response pipeline: all stages advance together, freeze on stall
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < readLatency; k++) begin
            r_vld[k] <= 1'b0;
            r_dat[k] <= '0;
         end
      end else if (!w_stall) begin
         r_vld[0] <= w_fire;
         if (w_fire)
            r_dat[0] <= w_rd_word;
         for (int k = 1; k < readLatency; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_dat[k] <= r_dat[k-1];
         end
      end
   end

endmodule

// File: tb/tb_ram_1w_1rs_stream.sv
// tb_ram_1w_1rs_stream: four configurations driven in lockstep,
// each checked against a queue-based response model.
module tb_ram_1w_1rs_stream;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_mask = '0;
   logic [7:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rd_cmd_valid = 1'b0;
   logic [7:0]  rd_cmd_addr = '0;
   logic        rd_rsp_ready = 1'b1;

   logic        cmd_ready [4];
   logic        rsp_valid [4];
   logic [31:0] rsp_data  [4];

   int cfg_lat [4] = '{1, 2, 2, 1};
   bit cfg_wf  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   int cfg_wc  [4] = '{256, 200, 200, 256};

   logic [31:0] mdl [256];
   logic [31:0] q_word [4][$];
   int          q_tag  [4][$];
   logic [31:0] log_w  [4][$];
   int          adv    [4] = '{0, 0, 0, 0};
   bit          fired  [4];
   bit          logging = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_1w_1rs_stream #(.wordCount(256), .readLatency(1),
      .readUnderWrite("writeFirst")) u_i0 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en),
      .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(cmd_ready[0]),
      .rd_cmd_addr(rd_cmd_addr), .rd_rsp_valid(rsp_valid[0]),
      .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rsp_data[0]));

   ram_1w_1rs_stream #(.wordCount(200), .readLatency(2),
      .readUnderWrite("readFirst")) u_i1 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en),
      .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(cmd_ready[1]),
      .rd_cmd_addr(rd_cmd_addr), .rd_rsp_valid(rsp_valid[1]),
      .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rsp_data[1]));

   ram_1w_1rs_stream #(.wordCount(200), .readLatency(2),
      .readUnderWrite("writeFirst")) u_i2 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en),
      .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(cmd_ready[2]),
      .rd_cmd_addr(rd_cmd_addr), .rd_rsp_valid(rsp_valid[2]),
      .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rsp_data[2]));

   ram_1w_1rs_stream #(.wordCount(256), .readLatency(1),
      .readUnderWrite("readFirst")) u_i3 (
      .clk(clk), .resetn(resetn), .wr_en(wr_en),
      .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(cmd_ready[3]),
      .rd_cmd_addr(rd_cmd_addr), .rd_rsp_valid(rsp_valid[3]),
      .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rsp_data[3]));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int i,
                                          input logic [7:0] a);
      logic [31:0] v;
      if (int'(a) >= cfg_wc[i]) return 32'h0;
      v = mdl[a];
      if (cfg_wf[i] && wr_en && wr_addr == a)
         for (int l = 0; l < 4; l++)
            if (wr_mask[l]) v[l*8 +: 8] = wr_data[l*8 +: 8];
      return v;
   endfunction

   function automatic bit busy();
      busy = 1'b0;
      for (int i = 0; i < 4; i++)
         if (q_word[i].size() > 0) busy = 1'b1;
   endfunction

   task automatic drv(input bit we, input logic [3:0] m,
                      input logic [7:0] wa, input logic [31:0] wd,
                      input bit rv, input logic [7:0] ra,
                      input bit rr);
      wr_en = we; wr_mask = m; wr_addr = wa; wr_data = wd;
      rd_cmd_valid = rv; rd_cmd_addr = ra; rd_rsp_ready = rr;
   endtask

   // one cycle: check outputs, then apply the edge to the model
   task automatic step();
      bit          ev [4];
      bit          st [4];
      logic [31:0] w  [4];
      #1;
      for (int i = 0; i < 4; i++) begin
         ev[i] = (q_word[i].size() > 0) &&
                 (q_tag[i][0] + cfg_lat[i] - 1 <= adv[i]);
         chk($sformatf("vld%0d", i), 32'(rsp_valid[i]), 32'(ev[i]));
         if (ev[i])
            chk($sformatf("dat%0d", i), rsp_data[i], q_word[i][0]);
         st[i] = ev[i] && !rd_rsp_ready;
         chk($sformatf("rdy%0d", i), 32'(cmd_ready[i]), 32'(!st[i]));
         fired[i] = resetn && rd_cmd_valid && !st[i];
         w[i] = exp_rd(i, rd_cmd_addr);
      end
      @(posedge clk);
      if (resetn) begin
         for (int i = 0; i < 4; i++) begin
            if (ev[i] && rd_rsp_ready) begin
               if (logging) log_w[i].push_back(q_word[i][0]);
               void'(q_word[i].pop_front());
               void'(q_tag[i].pop_front());
            end
            if (!st[i]) adv[i]++;
            if (fired[i]) begin
               q_word[i].push_back(w[i]);
               q_tag[i].push_back(adv[i]);
            end
         end
         if (wr_en)
            for (int l = 0; l < 4; l++)
               if (wr_mask[l]) mdl[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b1);
      while (busy() && n < 20) begin
         step();
         n++;
      end
      chk("drain", 32'(busy()), 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_vld%0d", i), 32'(rsp_valid[i]), 32'h0);
         chk($sformatf("rst_dat%0d", i), rsp_data[i], 32'h0);
         chk($sformatf("rst_rdy%0d", i), 32'(cmd_ready[i]), 32'h1);
      end
      resetn = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 256; k++) begin
         drv(1'b1, 4'hF, 8'(k),
             (k < 8) ? 32'(32'h10 + k) : $urandom,
             1'b0, 8'h0, 1'b1);
         step();
      end

      logging = 1'b1;
      a = 0;
      for (int c = 0; c < 40 && a < 8; c++) begin
         drv((c >= 4 && c < 7) && a > 0, 4'hF, 8'(a - 1),
             32'hDEAD0000 | 32'(c), 1'b1, 8'(a),
             !(c >= 4 && c < 7));
         step();
         if (fired[2]) a++;
      end
      drain();
      logging = 1'b0;
      for (int i = 1; i < 3; i++) begin
         chk($sformatf("bp_cnt%0d", i), 32'(log_w[i].size()), 32'd8);
         for (int k = 0; k < 8 && k < log_w[i].size(); k++)
            chk($sformatf("bp_ord%0d_%0d", i, k), log_w[i][k],
                32'(32'h10 + k));
      end

      drv(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 8'h0, 1'b1);
      step();
      drv(1'b1, 4'h5, 8'd5, 32'h11223344, 1'b0, 8'h0, 1'b1);
      step();
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'd5, 1'b1);
      step();
      #1;
      chk("mask_vld", 32'(rsp_valid[0]), 32'h1);
      chk("mask_dat0", rsp_data[0], 32'hAA22CC44);
      chk("mask_dat3", rsp_data[3], 32'hAA22CC44);
      drain();

      drv(1'b1, 4'hF, 8'd3, 32'h0, 1'b0, 8'h0, 1'b1);
      step();
      drv(1'b1, 4'h3, 8'd3, 32'hFFFFFFFF, 1'b1, 8'd3, 1'b1);
      step();
      #1;
      chk("cf_wf_l1", rsp_data[0], 32'h0000FFFF);
      chk("cf_rf_l1", rsp_data[3], 32'h00000000);
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b1);
      step();
      #1;
      chk("cf_wf_l2", rsp_data[2], 32'h0000FFFF);
      chk("cf_rf_l2", rsp_data[1], 32'h00000000);
      drain();

      drv(1'b1, 4'hF, 8'd210, 32'h12345678, 1'b0, 8'h0, 1'b1);
      step();
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'd210, 1'b1);
      step();
      #1;
      chk("oor_wc256", rsp_data[0], 32'h12345678);
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b1);
      step();
      #1;
      chk("oor_vld", 32'(rsp_valid[1]), 32'h1);
      chk("oor_dat1", rsp_data[1], 32'h0);
      chk("oor_dat2", rsp_data[2], 32'h0);
      drain();

      for (int c = 0; c < 400; c++) begin
         logic [7:0] ra;
         ra = 8'($urandom);
         drv(1'($urandom_range(0, 1)), 4'($urandom),
             ($urandom_range(0, 3) == 0) ? ra : 8'($urandom),
             $urandom, ($urandom_range(0, 2) != 0), ra,
             ($urandom_range(0, 3) != 0));
         step();
      end
      drain();

      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'd7, 1'b1);
      step();
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'd6, 1'b1);
      step();
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b1);
      resetn = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mr_vld%0d", i), 32'(rsp_valid[i]), 32'h0);
         chk($sformatf("mr_dat%0d", i), rsp_data[i], 32'h0);
         q_word[i].delete();
         q_tag[i].delete();
      end
      drv(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 8'h0, 1'b1);
      step();
      resetn = 1'b1;
      drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'd5, 1'b1);
      step();
      #1;
      chk("mr_keep", rsp_data[0], mdl[5]);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
